// File: rtl/trig_mask_sequencer.sv
// rtl/trig_mask_sequencer.sv - shadowed trigger mask/force apply on reference edges, optional channel scan (MASK_SCAN_EN)
module trig_mask_sequencer #(
    parameter int NCHAN   = 12,
    parameter int DWELL_W = 8
) (
    input  logic               mclk_i,
    input  logic               rst_i,
    input  logic               wr_i,
    input  logic               wr_sel_i,
    input  logic [31:0]        wr_dat_i,
    input  logic               ref_pulse_i,
    input  logic               scan_start_i,
    input  logic               scan_abort_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [31:0]        mask_o,
    output logic [31:0]        force_o,
    output logic               apply_o,
    output logic               pending_o,
    output logic               scan_busy_o,
    output logic [3:0]         scan_chan_o
);

    logic        ref_prev;
    logic        ref_edge;
    logic [31:0] shadow_mask;
    logic [31:0] shadow_force;
    logic [31:0] mask_d;
    logic [31:0] force_d;
    logic        apply_d;
    logic        pending_d;
    logic        apply_shadow;

    assign ref_edge = ref_pulse_i & ~ref_prev;

`ifdef MASK_SCAN_EN
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_DWELL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         chan_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_eff;

    assign dwell_eff = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;

    // Mask with only the given channel enabled; everything else stays masked.
    function automatic logic [31:0] scan_mask(input logic [3:0] chan);
        logic [31:0] m;
        m       = '1;
        m[chan] = 1'b0;
        return m;
    endfunction

    // Scan state, dwell counter, channel and busy flag registers.
    always_ff @(posedge mclk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            scan_chan_o <= '0;
            scan_busy_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            scan_chan_o <= chan_d;
            scan_busy_o <= (state_d != S_IDLE);
        end
    end
`else
    logic unused_scan;
    assign unused_scan = ^{scan_start_i, scan_abort_i, dwell_i};
    assign scan_busy_o = 1'b0;
    assign scan_chan_o = 4'd0;
`endif

    // Next-state and next-output logic; a write always leaves pending set.
    always_comb begin
        mask_d       = mask_o;
        force_d      = force_o;
        apply_d      = 1'b0;
        pending_d    = pending_o;
        apply_shadow = 1'b0;
`ifdef MASK_SCAN_EN
        state_d = state_q;
        chan_d  = scan_chan_o;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ref_edge && pending_o) apply_shadow = 1'b1;
                if (scan_start_i) state_d = S_ARM;
            end
            S_ARM: begin
                if (scan_abort_i) begin
                    state_d = S_DONE;
                end else if (ref_edge) begin
                    state_d = S_DWELL;
                    chan_d  = 4'd0;
                    mask_d  = scan_mask(4'd0);
                    force_d = '0;
                    apply_d = 1'b1;
                    cnt_d   = DWELL_W'(1);
                end
            end
            S_DWELL: begin
                if (scan_abort_i) begin
                    state_d = S_DONE;
                end else if (ref_edge) begin
                    // >= so a dwell lowered mid-step takes effect at this edge
                    if (cnt_q >= dwell_eff) begin
                        if (scan_chan_o < 4'(NCHAN - 1)) begin
                            chan_d  = scan_chan_o + 4'd1;
                            mask_d  = scan_mask(scan_chan_o + 4'd1);
                            apply_d = 1'b1;
                            cnt_d   = DWELL_W'(1);
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + DWELL_W'(1);
                    end
                end
            end
            S_DONE: begin
                apply_shadow = 1'b1;
                state_d      = S_IDLE;
                chan_d       = 4'd0;
                cnt_d        = '0;
            end
            default: state_d = S_IDLE;
        endcase
`else
        if (ref_edge && pending_o) apply_shadow = 1'b1;
`endif
        if (apply_shadow) begin
            mask_d    = shadow_mask;
            force_d   = shadow_force;
            apply_d   = 1'b1;
            pending_d = 1'b0;
        end
        if (wr_i) pending_d = 1'b1;
    end

    // Shadow registers, edge detector and applied output words.
    always_ff @(posedge mclk_i) begin
        if (rst_i) begin
            ref_prev     <= 1'b0;
            shadow_mask  <= 32'hFFFF_FFFF;
            shadow_force <= '0;
            mask_o       <= 32'hFFFF_FFFF;
            force_o      <= '0;
            apply_o      <= 1'b0;
            pending_o    <= 1'b0;
        end else begin
            ref_prev  <= ref_pulse_i;
            mask_o    <= mask_d;
            force_o   <= force_d;
            apply_o   <= apply_d;
            pending_o <= pending_d;
            if (wr_i) begin
                if (wr_sel_i) shadow_force <= wr_dat_i;
                else          shadow_mask  <= wr_dat_i;
            end
        end
    end

endmodule

// File: doc/trig_mask_sequencer.md
# trig_mask_sequencer

Controller for the L1/L2 trigger path's `mask_i`/`force_i` configuration words.
- Host writes go into shadow registers.
- Shadow values are applied atomically to the trigger on the next reference-pulse edge, so scaler windows never straddle a mask change.
- An optional self-stepping single-channel scan enables one channel at a time for a programmable number of reference pulses, for per-channel L1 rate scans.
- Sits on the 33 MHz side between the register interface and the TURF processor's 32-bit mask input (mask in bits [11:0], force in bits [27:16]).

## Interface
Parameters:
- NCHAN, 12: number of trigger channels handled by the scan (bits [NCHAN-1:0]).
- DWELL_W, 8: width of the scan dwell count.

Ports:
- mclk_i  in  1  master 33 MHz clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- wr_i  in  1  write strobe, one cycle.
- wr_sel_i  in  1  0 = mask shadow, 1 = force shadow.
- wr_dat_i  in  32  write data.
- ref_pulse_i  in  1  reference pulse, already registered in mclk_i domain.
- scan_start_i  in  1  start-scan strobe.
- scan_abort_i  in  1  abort-scan strobe.
- dwell_i  in  DWELL_W  reference edges per scan step; 0 is treated as 1.
- mask_o  out  32  applied mask; 1 = channel masked.
- force_o  out  32  applied force word.
- apply_o  out  1  one-cycle pulse, coincident with any change of mask_o/force_o.
- pending_o  out  1  shadow differs from applied (write not yet applied).
- scan_busy_o  out  1  scan FSM not IDLE.
- scan_chan_o  out  4  channel currently enabled by the scan.

## Operation
- Reset values:
  - mask_o = shadow mask = 32'hFFFF_FFFF.
  - force_o = shadow force = 0.
  - apply_o = 0, pending_o = 0, scan_busy_o = 0, scan_chan_o = 0.
  - FSM = IDLE, dwell counter = 0.
- Ref edge = ref_pulse_i high while its previous-cycle sample was low. A pulse held high counts as one edge.
- Write: the selected shadow register is loaded and pending is set.
- IDLE behaviour:
  - On a ref edge with pending set: mask_o/force_o are loaded from the shadows, apply_o pulses, pending clears.
  - Write and ref edge in the same cycle: the edge applies the pre-write shadow, and pending stays set, so the new value is applied on the following edge.
- Scan FSM states: IDLE, ARM, DWELL, DONE.
  - IDLE -> ARM on scan_start_i. scan_start_i is ignored outside IDLE.
  - ARM -> DWELL on a ref edge.
    - scan_chan_o = 0.
    - mask_o = ~(1 << 0) in bits [NCHAN-1:0], 1 in bits [31:NCHAN].
    - force_o = 0, apply_o pulses, dwell counter = 1.
  - DWELL, on each ref edge:
    - If counter == max(dwell_i,1) and chan < NCHAN-1: chan++, mask_o re-formed for the new channel, apply_o pulses, counter = 1.
    - If counter == max(dwell_i,1) and chan == NCHAN-1: go to DONE.
    - Otherwise: counter++.
  - DONE (one cycle): mask_o/force_o loaded from the shadows, apply_o pulses, pending clears, go to IDLE.
  - scan_abort_i in ARM or DWELL: go to DONE next cycle, without waiting for a ref edge.
- While scan_busy_o is high:
  - Writes still load the shadows and set pending.
  - No shadow apply occurs on ref edges; shadows are applied only in DONE.
- Writes are never lost.
- Reset mid-scan returns every output to its reset value on the next clock edge.
- scan_busy_o is high in ARM, DWELL and DONE.

## Timing
- All outputs are registered.
- With ref_pulse_i rising in cycle k, mask_o/force_o change and apply_o is high in cycle k+1.
- Write in cycle k: pending_o is high in cycle k+1.
- scan_start_i in cycle k: scan_busy_o is high in cycle k+1.
- Abort in cycle k: DONE in cycle k+1, restored outputs and apply_o in cycle k+2, scan_busy_o low in cycle k+2.
- Full scan duration: NCHAN × max(dwell_i,1) ref edges after the arming edge, with apply_o pulsing NCHAN+1 times.
- dwell_i is sampled at each comparison; changing it mid-scan takes effect at the next ref edge.

## Configuration
- MASK_SCAN_EN defined: scan FSM, dwell counter and scan ports are functional as above.
- MASK_SCAN_EN undefined:
  - No scan logic is built; scan_start_i, scan_abort_i and dwell_i are ignored.
  - scan_busy_o = 0 and scan_chan_o = 0 constantly.
  - Shadow/apply behaviour is unchanged.

## Test plan
- Reset, then write mask 32'h0000_0F0F with no ref pulse: mask_o stays FFFF_FFFF and pending_o = 1. Pulse ref: mask_o = 0000_0F0F one cycle later, apply_o pulses once, pending_o = 0.
- Write force 32'h0001_0000 in the same cycle as a ref edge: no change at that edge. Next ref edge: force_o = 0001_0000.
- Hold ref_pulse_i high for 10 cycles: exactly one apply_o pulse.
- Scan with dwell_i = 3, NCHAN = 12, 40 ref edges:
  - mask_o steps FFFF_FFFE, FFFF_FFFD, … FFFF_F7FF, each held for 3 edges.
  - Then shadows are restored and scan_busy_o drops.
  - 13 apply_o pulses in total.
- Scan with dwell_i = 0, abort during channel 4 after a mask write of 0000_0000: restore to 0000_0000 two cycles after abort, with no ref edge needed.
- Assert rst_i mid-DWELL: the next cycle shows all reset values. Build with MASK_SCAN_EN undefined: scan_start_i produces no change.
